multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: fetch/decode/exec/mem/wb plus branch, output-wait and halt states.
// One state per cycle except FETCH/MEM/OUT_WAIT/HALTED (wait on handshake) and EXEC (MULDIV_LAT for MULT/DIV).
module multicycle_control #(
    parameter int MULDIV_EN  = 1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             instr_valid,
    input  logic             mem_ready,
    input  logic             out_ack,
    input  logic             resume,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             Jal,
    output logic             halt,
    output logic             output_flag,
    output logic             illegal,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [3:0]       ALU_ctr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_BRANCH   = 3'd5,
        S_OUT_WAIT = 3'd6,
        S_HALTED   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             run_q, run_d;
    logic             retire;

    logic       is_r, is_md, r_bad, r_legal;
    logic [3:0] alu_r;

    assign is_r = (op_q == 6'h00);

    always_comb begin
        alu_r = 4'd0;
        is_md = 1'b0;
        r_bad = 1'b0;
        case (fn_q)
            6'h18:        begin alu_r = 4'd8; is_md = 1'b1; end
            6'h1A:        begin alu_r = 4'd9; is_md = 1'b1; end
            6'h20:        alu_r = 4'd2;
            6'h22:        alu_r = 4'd6;
            6'h24:        alu_r = 4'd0;
            6'h25:        alu_r = 4'd1;
            6'h2A:        alu_r = 4'd5;
            6'h3A, 6'h3F: alu_r = 4'd10;
            6'h26:        alu_r = 4'd7;
            default:      r_bad = 1'b1;
        endcase
        r_legal = !r_bad && (!is_md || (MULDIV_EN != 0));
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fn_d        = fn_q;
        cnt_d       = cnt_q;
        run_d       = 1'b1;
        retire      = 1'b0;
        ir_write    = 1'b0;
        pc_inc      = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        Branch      = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        ALUSrc      = 1'b0;
        Jal         = 1'b0;
        halt        = 1'b0;
        output_flag = 1'b0;
        illegal     = 1'b0;
        RegDst      = 2'd0;
        MemtoReg    = 2'd0;
        ALU_ctr     = 4'd0;
        // run_q keeps every output low until the first edge after reset release
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (instr_valid) begin
                        ir_write = 1'b1;
                        pc_inc   = 1'b1;
                        op_d     = opcode;
                        fn_d     = funct;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = S_FETCH;
                    case (op_q)
                        6'h00: begin
                            if (r_legal) begin
                                state_d = S_EXEC;
                                cnt_d   = is_md ? 4'(MULDIV_LAT - 1) : 4'd0;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        6'h08, 6'h2A: begin
                            state_d = S_EXEC;
                            cnt_d   = 4'd0;
                        end
                        6'h23, 6'h2B:               state_d = S_MEM;
                        6'h04, 6'h05, 6'h07, 6'h01: state_d = S_BRANCH;
                        6'h3F:                      state_d = S_HALTED;
                        6'h2E:                      state_d = S_OUT_WAIT;
                        6'h02: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                            retire   = 1'b1;
                        end
                        6'h03: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                            RegWrite = 1'b1;
                            RegDst   = 2'd2;
                            MemtoReg = 2'd2;
                            Jal      = 1'b1;
                            retire   = 1'b1;
                        end
                        6'h0F: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                            retire   = 1'b1;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                S_EXEC: begin
                    ALUSrc  = !is_r;
                    ALU_ctr = is_r ? alu_r : ((op_q == 6'h2A) ? 4'd6 : 4'd2);
                    if (cnt_q == 4'd0) state_d = S_WB;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_MEM: begin
                    ALUSrc   = 1'b1;
                    ALU_ctr  = 4'd2;
                    MemRead  = (op_q == 6'h23);
                    MemWrite = (op_q == 6'h2B);
                    if (mem_ready) begin
                        if (op_q == 6'h2B) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = is_r ? 2'd1 : 2'd0;
                    MemtoReg = (op_q == 6'h23) ? 2'd1 : 2'd0;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    Branch   = 1'b1;
                    pc_write = 1'b1;
                    case (op_q)
                        6'h04:   ALU_ctr = 4'd10;
                        6'h05:   ALU_ctr = 4'd3;
                        6'h07:   ALU_ctr = 4'd4;
                        default: ALU_ctr = 4'd5;
                    endcase
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_OUT_WAIT: begin
                    output_flag = 1'b1;
                    if (out_ack) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    halt = 1'b1;
                    if (resume) state_d = S_FETCH;
                end
            endcase
        end
        icnt_d = icnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            cnt_q   <= 4'd0;
            icnt_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
            icnt_q  <= icnt_d;
            run_q   <= run_d;
        end
    end

    assign state       = state_q;
    assign instr_count = icnt_q;
endmodule
